mem_axi_rd_arbiter: RTL and testbench

//  Shares the single AXI4 read port of the DDR3 MIG (mem_axi_ar*/r*, mig_clk domain) between
//  NUM_MST read masters (CPU D/I-cache refill, VGA framebuffer fetch, DMA engines).

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_rr_pick.sv | 36 +++
 rtl/mem_axi_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_axi_rd_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the MIG read-port arbiter: FSM state encoding and the captured AR request.
// The struct field widths set the largest ID/address width the arbiter can carry.
package mem_arb_pkg;

    localparam int AR_ID_W   = 7;
    localparam int AR_ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    typedef struct packed {
        logic [AR_ID_W-1:0]   id;
        logic [AR_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ar_req_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping at N.
module mem_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               j;
    logic [IDX_W-1:0] jj;

    // Scan from the farthest offset down so the nearest requester overwrites earlier hits.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            jj = IDX_W'(j);
            if (req_i[jj]) begin
                gnt_o     = '0;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
                any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_axi_rd_arbiter.sv
// Shares the MIG AXI4 read port among NUM_MST masters: round-robin grant, one burst in flight,
// R beats routed to the granted master, sticky burst-length and stray-beat error flags.
module mem_axi_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 7
) (
    input  logic                      mig_clk,
    input  logic                      mig_aresetn,
    input  logic [NUM_MST-1:0]        s_arvalid,
    output logic [NUM_MST-1:0]        s_arready,
    input  logic [NUM_MST*ID_W-1:0]   s_arid,
    input  logic [NUM_MST*ADDR_W-1:0] s_araddr,
    input  logic [NUM_MST*8-1:0]      s_arlen,
    input  logic [NUM_MST*3-1:0]      s_arsize,
    input  logic [NUM_MST*2-1:0]      s_arburst,
    output logic [NUM_MST-1:0]        s_rvalid,
    input  logic [NUM_MST-1:0]        s_rready,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [ID_W-1:0]           s_rid,
    output logic [1:0]                s_rresp,
    output logic                      s_rlast,
    output logic [ID_W-1:0]           m_arid,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [ID_W-1:0]           m_rid,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    output logic                      err_len,
    output logic                      err_stray
);

    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    arb_state_t       state_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] gnt_idx_q;
    ar_req_t          ar_q;
    ar_req_t          ar_d;
    logic             m_arvalid_q;
    logic [8:0]       beat_cnt_q;
    logic [7:0]       exp_len_q;
    logic             err_len_q;
    logic             err_stray_q;

    logic [NUM_MST-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               r_hs;

    mem_rr_pick #(
        .N     (NUM_MST),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (s_arvalid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        ar_d = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                ar_d.id    = AR_ID_W'(s_arid[i*ID_W +: ID_W]);
                ar_d.addr  = AR_ADDR_W'(s_araddr[i*ADDR_W +: ADDR_W]);
                ar_d.len   = s_arlen[i*8 +: 8];
                ar_d.size  = s_arsize[i*3 +: 3];
                ar_d.burst = s_arburst[i*2 +: 2];
            end
        end
    end

    assign s_arready = (state_q == ARB_IDLE) ? pick_gnt : '0;
    assign m_rready  = (state_q == ARB_DATA) && s_rready[gnt_idx_q];
    assign r_hs      = (state_q == ARB_DATA) && m_rvalid && m_rready;

    always_comb begin
        s_rvalid = '0;
        if (state_q == ARB_DATA) s_rvalid[gnt_idx_q] = m_rvalid;
    end

    always_ff @(posedge mig_clk or negedge mig_aresetn) begin
        if (!mig_aresetn) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            ar_q        <= '0;
            m_arvalid_q <= 1'b0;
            beat_cnt_q  <= '0;
            exp_len_q   <= '0;
            err_len_q   <= 1'b0;
            err_stray_q <= 1'b0;
        end else begin
            if (m_rvalid && state_q != ARB_DATA) err_stray_q <= 1'b1;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        gnt_idx_q   <= pick_idx;
                        ar_q        <= ar_d;
                        m_arvalid_q <= 1'b1;
                        state_q     <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (m_arready) begin
                        m_arvalid_q <= 1'b0;
                        beat_cnt_q  <= '0;
                        exp_len_q   <= ar_q.len;
                        state_q     <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (m_rlast) begin
                            if (beat_cnt_q != {1'b0, exp_len_q}) err_len_q <= 1'b1;
                            rr_ptr_q <= IDX_W'(rr_next(int'(gnt_idx_q), NUM_MST));
                            state_q  <= ARB_IDLE;
                        end else if (beat_cnt_q == {1'b0, exp_len_q}) begin
                            // Final expected beat without rlast: flag it, keep draining until rlast.
                            err_len_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign m_arvalid = m_arvalid_q;
    assign m_arid    = ID_W'(ar_q.id);
    assign m_araddr  = ADDR_W'(ar_q.addr);
    assign m_arlen   = ar_q.len;
    assign m_arsize  = ar_q.size;
    assign m_arburst = ar_q.burst;

    assign s_rdata   = m_rdata;
    assign s_rid     = m_rid;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;

    assign err_len   = err_len_q;
    assign err_stray = err_stray_q;

endmodule

// File: tb/tb_mem_axi_rd_arbiter.sv
// Directed bench for mem_axi_rd_arbiter with two masters and a hand-driven MIG read port.
module tb_mem_axi_rd_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 7;

    logic             clk = 1'b0;
    logic             mig_aresetn;
    logic [NM-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NM*IW-1:0] s_arid;
    logic [NM*AW-1:0] s_araddr;
    logic [NM*8-1:0]  s_arlen;
    logic [NM*3-1:0]  s_arsize;
    logic [NM*2-1:0]  s_arburst;
    logic [DW-1:0]    s_rdata;
    logic [IW-1:0]    s_rid;
    logic [1:0]       s_rresp;
    logic             s_rlast;
    logic [IW-1:0]    m_arid;
    logic [AW-1:0]    m_araddr;
    logic [7:0]       m_arlen;
    logic [2:0]       m_arsize;
    logic [1:0]       m_arburst;
    logic             m_arvalid, m_arready;
    logic [IW-1:0]    m_rid;
    logic [DW-1:0]    m_rdata;
    logic [1:0]       m_rresp;
    logic             m_rlast, m_rvalid, m_rready;
    logic             err_len, err_stray;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_axi_rd_arbiter #(.NUM_MST(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .mig_clk(clk), .mig_aresetn(mig_aresetn),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .err_len(err_len), .err_stray(err_stray)
    );

    task automatic set_fields(input int m, input logic [6:0] id, input logic [31:0] addr,
                              input logic [7:0] len);
        s_arid[m*IW +: IW]   = id;
        s_araddr[m*AW +: AW] = addr;
        s_arlen[m*8 +: 8]    = len;
        s_arsize[m*3 +: 3]   = 3'b010;
        s_arburst[m*2 +: 2]  = 2'b01;
    endtask

    task automatic do_reset();
        mig_aresetn = 1'b0;
        s_arvalid   = '0;
        m_rvalid    = 1'b0;
        m_rlast     = 1'b0;
        repeat (2) @(posedge clk);
        #1 mig_aresetn = 1'b1;
    endtask

    // Raise arvalid for master m and wait for its grant; w = cycles waited, -1 on timeout.
    task automatic issue_req(input int m, output int w);
        w = -1;
        s_arvalid[m] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_arready[m]) begin
                w = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_arvalid[m] = 1'b0;
    endtask

    // Wait for m_arvalid (m_arready held high) and capture the AR fields.
    task automatic wait_ar(output int c, output logic [31:0] a, output logic [7:0] l,
                           output logic [6:0] id);
        c = -1; a = '0; l = '0; id = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_arvalid) begin
                c = i; a = m_araddr; l = m_arlen; id = m_arid;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // One MIG beat, assuming the granted master is ready.
    task automatic beat(input logic [31:0] d, input logic last, output logic [1:0] rv,
                        output logic [31:0] rd, output logic rr, output logic rl);
        m_rvalid = 1'b1; m_rdata = d; m_rlast = last;
        @(negedge clk);
        rv = s_rvalid; rd = s_rdata; rr = m_rready; rl = s_rlast;
        @(posedge clk); #1;
        m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    task automatic test_reset();
        mig_aresetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL rst_arvalid got %b exp 0", m_arvalid); end
        tests++; if (m_araddr !== 32'h0) begin fails++; $display("FAIL rst_araddr got %h exp 0", m_araddr); end
        tests++; if (s_arready !== 2'b00) begin fails++; $display("FAIL rst_arready got %b exp 00", s_arready); end
        tests++; if (s_rvalid !== 2'b00) begin fails++; $display("FAIL rst_rvalid got %b exp 00", s_rvalid); end
        tests++; if (m_rready !== 1'b0) begin fails++; $display("FAIL rst_rready got %b exp 0", m_rready); end
        tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL rst_err_len got %b exp 0", err_len); end
        tests++; if (err_stray !== 1'b0) begin fails++; $display("FAIL rst_err_stray got %b exp 0", err_stray); end
        @(posedge clk); #1 mig_aresetn = 1'b1;
    endtask

    task automatic test_single();
        int w, c; logic [31:0] a, rd; logic [7:0] l; logic [6:0] id;
        logic [1:0] rv; logic rr, rl;
        set_fields(0, 7'h11, 32'h1000, 8'd3);
        issue_req(0, w);
        tests++; if (w !== 0) begin fails++; $display("FAIL single_grant_wait got %0d exp 0", w); end
        wait_ar(c, a, l, id);
        tests++; if (c !== 0) begin fails++; $display("FAIL single_ar_latency got %0d exp 0", c); end
        tests++; if (a !== 32'h1000) begin fails++; $display("FAIL single_araddr got %h exp 1000", a); end
        tests++; if (l !== 8'd3) begin fails++; $display("FAIL single_arlen got %0d exp 3", l); end
        tests++; if (id !== 7'h11) begin fails++; $display("FAIL single_arid got %h exp 11", id); end
        for (int b = 0; b < 4; b++) begin
            beat(32'hA000 + b, b == 3, rv, rd, rr, rl);
            tests++; if (rv !== 2'b01) begin fails++; $display("FAIL single_rvalid b%0d got %b exp 01", b, rv); end
            tests++; if (rd !== 32'hA000 + b) begin fails++; $display("FAIL single_rdata b%0d got %h exp %h", b, rd, 32'hA000 + b); end
            tests++; if (rr !== 1'b1) begin fails++; $display("FAIL single_mrready b%0d got %b exp 1", b, rr); end
            tests++; if (rl !== (b == 3)) begin fails++; $display("FAIL single_rlast b%0d got %b exp %b", b, rl, b == 3); end
        end
        @(negedge clk);
        tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL single_err_len got %b exp 0", err_len); end
    endtask

    task automatic test_round_robin();
        logic [1:0] rv; logic [31:0] rd, ea; logic rr, rl; int g;
        do_reset();
        set_fields(0, 7'h20, 32'h2000, 8'd0);
        set_fields(1, 7'h21, 32'h3000, 8'd0);
        s_arvalid = 2'b11;
        for (int r = 0; r < 4; r++) begin
            g  = r % 2;
            ea = (g == 0) ? 32'h2000 : 32'h3000;
            @(negedge clk);
            tests++; if (s_arready !== (2'b01 << g)) begin fails++; $display("FAIL rr_grant r%0d got %b exp %b", r, s_arready, 2'b01 << g); end
            @(posedge clk); #1;
            @(negedge clk);
            tests++; if (s_arready !== 2'b00) begin fails++; $display("FAIL rr_no_grant_addr r%0d got %b exp 00", r, s_arready); end
            tests++; if (m_araddr !== ea) begin fails++; $display("FAIL rr_araddr r%0d got %h exp %h", r, m_araddr, ea); end
            @(posedge clk); #1;
            beat(32'hB000 + r, 1'b1, rv, rd, rr, rl);
            if (r == 3) s_arvalid = 2'b00;
            tests++; if (rv !== (2'b01 << g)) begin fails++; $display("FAIL rr_rvalid r%0d got %b exp %b", r, rv, 2'b01 << g); end
        end
    endtask

    task automatic test_short_burst();
        int w, c; logic [31:0] a, rd; logic [7:0] l; logic [6:0] id;
        logic [1:0] rv; logic rr, rl;
        set_fields(0, 7'h30, 32'h4000, 8'd3);
        issue_req(0, w);
        wait_ar(c, a, l, id);
        beat(32'hC000, 1'b0, rv, rd, rr, rl);
        beat(32'hC001, 1'b1, rv, rd, rr, rl);
        @(negedge clk);
        tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL short_err_len got %b exp 1", err_len); end
        @(posedge clk); #1;
        set_fields(0, 7'h31, 32'h4100, 8'd0);
        issue_req(0, w);
        tests++; if (w !== 0) begin fails++; $display("FAIL short_next_grant got %0d exp 0", w); end
        wait_ar(c, a, l, id);
        tests++; if (a !== 32'h4100) begin fails++; $display("FAIL short_next_addr got %h exp 4100", a); end
        beat(32'hC100, 1'b1, rv, rd, rr, rl);
        tests++; if (rv !== 2'b01 || rd !== 32'hC100) begin fails++; $display("FAIL short_next_beat got %b/%h exp 01/c100", rv, rd); end
        tests++; if (err_stray !== 1'b0) begin fails++; $display("FAIL short_err_stray got %b exp 0", err_stray); end
    endtask

    task automatic test_stray();
        m_rvalid = 1'b1; m_rdata = 32'hDEAD0000;
        @(negedge clk);
        tests++; if (m_rready !== 1'b0) begin fails++; $display("FAIL stray_mrready got %b exp 0", m_rready); end
        tests++; if (s_rvalid !== 2'b00) begin fails++; $display("FAIL stray_rvalid got %b exp 00", s_rvalid); end
        @(posedge clk); #1 m_rvalid = 1'b0;
        @(negedge clk);
        tests++; if (err_stray !== 1'b1) begin fails++; $display("FAIL stray_flag got %b exp 1", err_stray); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int w, c; logic [31:0] a, rd; logic [7:0] l; logic [6:0] id;
        logic [1:0] rv; logic rr, rl;
        set_fields(1, 7'h40, 32'h5000, 8'd3);
        issue_req(1, w);
        tests++; if (w !== 0) begin fails++; $display("FAIL bp_grant got %0d exp 0", w); end
        wait_ar(c, a, l, id);
        beat(32'hE000, 1'b0, rv, rd, rr, rl);
        tests++; if (rv !== 2'b10 || rd !== 32'hE000) begin fails++; $display("FAIL bp_beat0 got %b/%h exp 10/e000", rv, rd); end
        s_rready[1] = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hE001; m_rlast = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++; if (m_rready !== 1'b0) begin fails++; $display("FAIL bp_stall_rready c%0d got %b exp 0", k, m_rready); end
            tests++; if (s_rvalid !== 2'b10 || s_rdata !== 32'hE001) begin fails++; $display("FAIL bp_stall_hold c%0d got %b/%h exp 10/e001", k, s_rvalid, s_rdata); end
            @(posedge clk); #1;
        end
        s_rready[1] = 1'b1;
        @(negedge clk);
        tests++; if (m_rready !== 1'b1) begin fails++; $display("FAIL bp_release got %b exp 1", m_rready); end
        @(posedge clk); #1 m_rvalid = 1'b0;
        for (int b = 2; b < 4; b++) begin
            beat(32'hE000 + b, b == 3, rv, rd, rr, rl);
            tests++; if (rv !== 2'b10 || rd !== 32'hE000 + b) begin fails++; $display("FAIL bp_beat%0d got %b/%h exp 10/%h", b, rv, rd, 32'hE000 + b); end
        end
        @(negedge clk);
        tests++; if (m_rready !== 1'b0 || s_rvalid !== 2'b00) begin fails++; $display("FAIL bp_idle_after got %b/%b exp 0/00", m_rready, s_rvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        int w, c; logic [31:0] a, rd; logic [7:0] l; logic [6:0] id;
        logic [1:0] rv; logic rr, rl;
        do_reset();
        set_fields(0, 7'h50, 32'h6000, 8'd0);
        issue_req(0, w);
        wait_ar(c, a, l, id);
        beat(32'hF000, 1'b1, rv, rd, rr, rl);
        set_fields(1, 7'h51, 32'h7000, 8'd7);
        issue_req(1, w);
        wait_ar(c, a, l, id);
        beat(32'hF100, 1'b0, rv, rd, rr, rl);
        beat(32'hF101, 1'b0, rv, rd, rr, rl);
        m_rvalid = 1'b1; m_rdata = 32'hF102;
        mig_aresetn = 1'b0;
        #1 m_rvalid = 1'b0;
        @(negedge clk);
        tests++; if (s_rvalid !== 2'b00 || m_rready !== 1'b0) begin fails++; $display("FAIL midrst_r got %b/%b exp 00/0", s_rvalid, m_rready); end
        tests++; if (m_arvalid !== 1'b0 || m_araddr !== 32'h0 || m_arlen !== 8'h0) begin fails++; $display("FAIL midrst_ar got %b/%h/%h exp 0/0/0", m_arvalid, m_araddr, m_arlen); end
        tests++; if (err_len !== 1'b0 || err_stray !== 1'b0) begin fails++; $display("FAIL midrst_err got %b/%b exp 0/0", err_len, err_stray); end
        mig_aresetn = 1'b1;
        @(posedge clk); #1;
        set_fields(0, 7'h52, 32'h8000, 8'd0);
        set_fields(1, 7'h53, 32'h9000, 8'd0);
        s_arvalid = 2'b11;
        @(negedge clk);
        tests++; if (s_arready !== 2'b01) begin fails++; $display("FAIL midrst_rr_ptr got %b exp 01", s_arready); end
        @(posedge clk); #1 s_arvalid = 2'b00;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        mig_aresetn = 1'b0;
        s_arvalid = '0; s_rready = '1;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        m_arready = 1'b1;
        m_rid = 7'h11; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_short_burst();
        test_stray();
        test_backpressure();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "watchdog");
    end

endmodule
